// File: rtl/hex_scan_mux_if.sv
// hex_scan_mux_if: valid/ready load channel carrying the packed hex word
interface hex_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    valid;
  logic                    ready;
  modport master (output value, valid, input ready);
  modport slave (input value, valid, output ready);
endinterface

// File: rtl/hex_scan_mux.sv
// hex_scan_mux: double-buffered multiplexed 7-seg digit scanner with guard gaps; LEADING_ZERO_BLANK_EN blanks leading zeros
module hex_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_scan_mux_if.slave         load,
  output logic [3:0]            hex_digit,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic                  frame_done
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_ON   = PW'(REFRESH_DIV - GAP_CYCLES);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                state, state_nx;
  logic [PW-1:0]         presc, presc_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [W-1:0]          display_reg, dreg_nx, pending;
  logic                  pending_valid, pv_nx;
  logic                  xfer, last, wrap, scan, active;
  logic [NUM_DIGITS-1:0] blank, sel;
  logic [3:0]            hex_nx;
  always_comb begin
    scan     = state == SCAN;
    xfer     = load.valid && load.ready;
    last     = scan && presc == P_LAST;
    wrap     = last && idx == I_LAST;
    state_nx = (!scan && xfer) ? SCAN : state;
    presc_nx = (!scan || last) ? '0 : presc + 1'b1;
    idx_nx   = (!scan || wrap) ? '0 : last ? idx + 1'b1 : idx;
    dreg_nx  = !scan ? (xfer ? load.value : display_reg) : (wrap && pending_valid) ? pending : display_reg;
    pv_nx    = (wrap && pending_valid) ? 1'b0 : (scan && xfer) ? 1'b1 : pending_valid;
    active   = state_nx == SCAN && presc_nx < P_ON;
    sel      = NUM_DIGITS'(1) << idx_nx;
    hex_nx   = 4'(dreg_nx >> {idx_nx, 2'b00});
    blank    = '0;
`ifdef LEADING_ZERO_BLANK_EN
    // digit i is dark when it and every digit above it are zero
    for (int i = 1; i < NUM_DIGITS; i++) blank[i] = (dreg_nx >> (4 * i)) == '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      presc         <= '0;
      idx           <= '0;
      display_reg   <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      load.ready    <= 1'b1;
      hex_digit     <= '0;
      digit_en_n    <= '1;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      presc         <= presc_nx;
      idx           <= idx_nx;
      display_reg   <= dreg_nx;
      pending       <= (scan && xfer) ? load.value : pending;
      pending_valid <= pv_nx;
      load.ready    <= !pv_nx;
      hex_digit     <= active ? hex_nx : hex_digit;
      digit_en_n    <= active ? (~sel | blank) : '1;
      frame_done    <= wrap;
    end
  end
endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux: directed checks of reset, scan timing, double buffering and mid-scan reset
module tb_hex_scan_mux;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] hex_digit;
  logic [3:0] digit_en_n;
  logic       frame_done;
  int         errors = 0;
  int         checks = 0;
  hex_scan_mux_if #(.NUM_DIGITS(4)) load ();
  hex_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hex_digit  (hex_digit),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic blank_chk(input string tag);
    chk({tag, "_en"}, 32'(digit_en_n), 32'hF);
    chk({tag, "_hex"}, 32'(hex_digit), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    chk({tag, "_rdy"}, 32'(load.ready), 32'h1);
  endtask
  // one 32-cycle frame starting at presc=0/idx=0; optional load driven at cycle ld_at
  task automatic frame(input logic [15:0] v, input logic fd0, input logic rdy0,
                       input int ld_at, input logic [15:0] ld_val);
    int         p, d;
    logic [3:0] en_x;
    for (int c = 0; c < 32; c++) begin
      p    = c % 8;
      d    = c / 8;
      en_x = (p < 6) ? ~(4'b0001 << d) : 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (v >> (4 * d)) == 16'h0) en_x = 4'hF;
`endif
      chk("scan_en", 32'(digit_en_n), 32'(en_x));
      chk("scan_hex", 32'(hex_digit), 32'(v[4*d +: 4]));
      chk("frame_done", 32'(frame_done), (c == 0) ? 32'(fd0) : 32'h0);
      chk("load_ready", 32'(load.ready), (ld_at >= 0 && c > ld_at) ? 32'h0 : 32'(rdy0));
      if (c == ld_at) begin
        load.valid = 1'b1;
        load.value = ld_val;
      end
      if (ld_at >= 0 && c == ld_at + 1) load.value = 16'hBEEF;
      step();
    end
  endtask
  task automatic first_load(input logic [15:0] v);
    load.valid = 1'b1;
    load.value = v;
    step();
    load.valid = 1'b0;
  endtask
  initial begin
    rst_n      = 1'b0;
    load.valid = 1'b0;
    load.value = '0;
    repeat (3) step();
    blank_chk("reset");
    rst_n = 1'b1;
    repeat (5) begin
      step();
      blank_chk("idle");
    end
    first_load(16'h3A7F);
    frame(16'h3A7F, 1'b0, 1'b1, -1, 16'h0);
    frame(16'h3A7F, 1'b1, 1'b1, 10, 16'h1234);
    load.valid = 1'b0;
    frame(16'h1234, 1'b1, 1'b1, -1, 16'h0);
    frame(16'h1234, 1'b1, 1'b1, 31, 16'hC0DE);
    load.valid = 1'b0;
    frame(16'h1234, 1'b1, 1'b0, -1, 16'h0);
    frame(16'hC0DE, 1'b1, 1'b1, -1, 16'h0);
    load.valid = 1'b1;
    load.value = 16'h9999;
    step();
    load.valid = 1'b0;
    chk("pend_rdy", 32'(load.ready), 32'h0);
    repeat (16) step();
    chk("slot2_en", 32'(digit_en_n), 32'hB);
    chk("slot2_hex", 32'(hex_digit), 32'h0);
    rst_n = 1'b0;
    step();
    blank_chk("midreset");
    rst_n = 1'b1;
    repeat (40) begin
      step();
      blank_chk("postreset");
    end
    first_load(16'hABCD);
    chk("reload_en", 32'(digit_en_n), 32'hE);
    chk("reload_hex", 32'(hex_digit), 32'hD);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    first_load(16'h0050);
    frame(16'h0050, 1'b0, 1'b1, -1, 16'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    first_load(16'h0000);
    frame(16'h0000, 1'b0, 1'b1, -1, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
